// File: rtl/progmem_loader_if.sv
// Fetch port and programmer byte-stream signals of the program memory loader.
// The slave side is the memory block; the master side is the CPU/programmer.
interface progmem_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) ();
  logic              fetch_en_i;
  logic [ADDR_W-1:0] fetch_adr_i;
  logic [DATA_W-1:0] fetch_dat_o;
  logic              fetch_vld_o;
  logic              cpu_hold_o;
  logic              load_start_i;
  logic              load_end_i;
  logic              byte_vld_i;
  logic [7:0]        byte_i;
  logic              byte_rdy_o;
  logic [ADDR_W:0]   words_o;
  logic              ovf_o;

  modport slave (
    input  fetch_en_i, fetch_adr_i, load_start_i, load_end_i, byte_vld_i, byte_i,
    output fetch_dat_o, fetch_vld_o, cpu_hold_o, byte_rdy_o, words_o, ovf_o
  );

  modport master (
    output fetch_en_i, fetch_adr_i, load_start_i, load_end_i, byte_vld_i, byte_i,
    input  fetch_dat_o, fetch_vld_o, cpu_hold_o, byte_rdy_o, words_o, ovf_o
  );
endinterface

// File: rtl/progmem_loader.sv
// Instruction memory with a registered fetch port and a built-in loader that
// packs a little-endian byte stream into words written from address 0 upward.
module progmem_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14
) (
  input  logic rom_clk_i,
  input  logic rom_rstn_i,
  progmem_loader_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {RUN, LOAD, FULL} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] fetch_dat_q, fetch_dat_d;
  logic              fetch_vld_q, fetch_vld_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              byte_rdy_q, byte_rdy_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] asm_q, asm_d;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              mem_we;
  logic [DATA_W-1:0] asm_with;
  logic              byte_acc;
  logic              word_done;

  always_comb begin
    byte_acc  = (state_q == LOAD) && bus.byte_vld_i && !bus.load_start_i;
    word_done = byte_acc && (idx_q == IDX_W'(NB - 1));
    // Assembly register with the accepted byte merged; upper lanes stay zero,
    // which doubles as the padding for a flushed partial word.
    asm_with = asm_q;
    for (int l = 0; l < NB; l++) begin
      if (byte_acc && (idx_q == IDX_W'(l))) asm_with[l*8 +: 8] = bus.byte_i;
    end

    state_d     = state_q;
    fetch_dat_d = fetch_dat_q;
    fetch_vld_d = 1'b0;
    words_d     = words_q;
    ovf_d       = ovf_q;
    waddr_d     = waddr_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    mem_we      = 1'b0;

    case (state_q)
      RUN: begin
        if (bus.fetch_en_i) begin
          fetch_dat_d = mem[bus.fetch_adr_i];
          fetch_vld_d = 1'b1;
        end
      end
      LOAD: begin
        fetch_dat_d = '0;
        if (byte_acc) begin
          asm_d = asm_with;
          idx_d = idx_q + 1'b1;
        end
        if (word_done) begin
          mem_we  = 1'b1;
          waddr_d = waddr_q + 1'b1;
          words_d = words_q + 1'b1;
          idx_d   = '0;
          asm_d   = '0;
          if (waddr_q == '1) state_d = FULL;
        end
        if (bus.load_end_i) begin
          if (!word_done && (byte_acc || idx_q != '0)) begin
            mem_we  = 1'b1;
            waddr_d = waddr_q + 1'b1;
            words_d = words_q + 1'b1;
            idx_d   = '0;
            asm_d   = '0;
          end
          state_d = RUN;
        end
      end
      FULL: begin
        fetch_dat_d = '0;
        if (bus.byte_vld_i) ovf_d = 1'b1;
        if (bus.load_end_i) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    // A new load restarts from scratch and wins over any end/flush this cycle.
    if (bus.load_start_i) begin
      state_d = LOAD;
      waddr_d = '0;
      idx_d   = '0;
      asm_d   = '0;
      words_d = '0;
      ovf_d   = 1'b0;
      mem_we  = 1'b0;
    end

    cpu_hold_d = (state_d != RUN);
    byte_rdy_d = (state_d == LOAD);
  end

  always_ff @(posedge rom_clk_i or negedge rom_rstn_i) begin
    if (!rom_rstn_i) begin
      state_q     <= RUN;
      fetch_dat_q <= '0;
      fetch_vld_q <= 1'b0;
      cpu_hold_q  <= 1'b0;
      byte_rdy_q  <= 1'b0;
      words_q     <= '0;
      ovf_q       <= 1'b0;
      waddr_q     <= '0;
      idx_q       <= '0;
      asm_q       <= '0;
    end else begin
      state_q     <= state_d;
      fetch_dat_q <= fetch_dat_d;
      fetch_vld_q <= fetch_vld_d;
      cpu_hold_q  <= cpu_hold_d;
      byte_rdy_q  <= byte_rdy_d;
      words_q     <= words_d;
      ovf_q       <= ovf_d;
      waddr_q     <= waddr_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
    end
  end

  // The array has no reset so that program contents survive a CPU reset.
  always_ff @(posedge rom_clk_i) begin
    if (mem_we) mem[waddr_q] <= asm_with;
  end

  assign bus.fetch_dat_o = fetch_dat_q;
  assign bus.fetch_vld_o = fetch_vld_q;
  assign bus.cpu_hold_o  = cpu_hold_q;
  assign bus.byte_rdy_o  = byte_rdy_q;
  assign bus.words_o     = words_q;
  assign bus.ovf_o       = ovf_q;
endmodule

// File: doc/progmem_loader.md
# progmem_loader

Parametrised instruction memory with a built-in serial-stream loader, replacing the fixed 32-bit × 16K program ROM with its external programmer mux. The block holds a synchronous word array that the CPU fetch unit reads. In LOAD mode it also assembles a little-endian byte stream from the UART programmer into words and writes them sequentially from address 0. All logic runs on one clock; the loader/CPU arbitration is an internal state machine rather than an external kick-off mux.

## Interface
Parameters:
- DATA_W, 32, instruction word width; multiple of 8; NB = DATA_W/8 bytes per word
- ADDR_W, 14, word address width; depth = 2^ADDR_W words

Ports:
- rom_clk_i  in  1  clock for array, loader and fetch port
- rom_rstn_i  in  1  reset; one clock; asynchronous, active-low
- fetch_en_i  in  1  CPU fetch request
- fetch_adr_i  in  ADDR_W  CPU word address
- fetch_dat_o  out  DATA_W  fetched instruction, registered
- fetch_vld_o  out  1  fetch_dat_o holds valid data for the previous request
- cpu_hold_o  out  1  high while loading; the CPU must stall
- load_start_i  in  1  pulse: enter LOAD, rewind to address 0
- load_end_i  in  1  pulse: finish LOAD, flush any partial word
- byte_vld_i  in  1  programmer byte valid
- byte_i  in  8  programmer byte, least-significant byte of each word first
- byte_rdy_o  out  1  block accepts byte_i this cycle
- words_o  out  ADDR_W+1  words written in the current or last load
- ovf_o  out  1  sticky: byte offered while the array was full

## Operation
- States: RUN, LOAD, FULL. Reset enters RUN. Array contents are not cleared by reset.
- Reset values:
  - fetch_dat_o = 0, fetch_vld_o = 0, cpu_hold_o = 0, byte_rdy_o = 0
  - words_o = 0, ovf_o = 0
  - internal write address = 0, byte index = 0, assembly register = 0
- RUN:
  - cpu_hold_o = 0, byte_rdy_o = 0.
  - When fetch_en_i=1: fetch_dat_o <= mem[fetch_adr_i] and fetch_vld_o <= 1. Otherwise fetch_vld_o <= 0 and fetch_dat_o holds its value.
  - load_start_i → LOAD.
- LOAD:
  - cpu_hold_o = 1 and byte_rdy_o = 1.
  - Fetch is ignored: fetch_vld_o <= 0, fetch_dat_o <= 0.
  - Accepted byte (byte_vld_i & byte_rdy_o) goes into byte lane [index].
  - If index = NB-1, the completed word {byte_i, lanes NB-2..0} is written to mem[waddr] on the same edge. Then waddr++, words_o++, index <= 0, assembly <= 0.
  - Otherwise index++.
  - A full word written at waddr = 2^ADDR_W-1 → FULL.
- FULL:
  - cpu_hold_o = 1, byte_rdy_o = 0.
  - byte_vld_i=1 sets ovf_o. Bytes are dropped.
  - load_end_i → RUN.
- load_end_i in LOAD:
  - If index ≠ 0, write the partial word zero-padded in the upper lanes to mem[waddr] and increment words_o.
  - A byte accepted on the same cycle is included before the flush.
  - Then → RUN.
- load_start_i in any state: waddr <= 0, index <= 0, words_o <= 0, ovf_o <= 0, → LOAD.
  - It overrides load_end_i on the same cycle.
  - A byte presented on the same cycle is not accepted.
- Assertion of rom_rstn_i mid-load abandons the load: state → RUN, the partial word is lost, and words already written remain.

## Timing
- Fetch latency: 1 cycle. Address at edge N, data and fetch_vld_o after edge N.
- Byte-to-array: the word is written on the edge that accepts its last byte. A fetch of that address in RUN sees the new data.
- Mode changes take effect on the edge after the pulse. cpu_hold_o rises the cycle after load_start_i and falls the cycle after load_end_i.
- byte_rdy_o is registered state-derived: 1 exactly while in LOAD.
- Full load of 2^ADDR_W words takes NB·2^ADDR_W accepted bytes, one byte per cycle maximum.

## Test plan
- Reset then fetch with preloaded mem[5]=0xDEADBEEF: fetch_en_i=1, adr=5 → next cycle fetch_dat_o=0xDEADBEEF, fetch_vld_o=1. All outputs 0 during reset.
- Load sequence: load_start, bytes EF BE AD DE 78 56 34 12, load_end → mem[0]=0xDEADBEEF, mem[1]=0x12345678, words_o=2, cpu_hold_o back to 0.
- Partial word: load_start, bytes 11 22 33, load_end → mem[0]=0x00332211, words_o=1.
- Overflow with ADDR_W=2: load 16 bytes → FULL, byte_rdy_o=0. A 17th byte sets ovf_o=1, and mem[0..3] is unchanged by it. The next load_start clears ovf_o.
- Collisions: load_start_i and load_end_i together → LOAD with words_o=0. load_end_i together with the 4th byte → one full word written, no extra zero word.
- Reset mid-load after 6 bytes → RUN, mem[0] written, bytes 5–6 discarded, fetches from address 0 return the new word.
